// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcodes, ALU op codes and the per-lane control bundle.
// Pure types/constants, no timing or backpressure of its own.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [2:0] ALU_R   = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef struct packed {
    logic       regwrite;
    logic       regdst;
    logic       alusrc;
    logic       branchbeq;
    logic       branchneq;
    logic       memwrite;
    logic       memtoreg;
    logic       jump;
    logic       jumplink;
    logic       userd1;
    logic       userd2;
    logic [2:0] aluop;
  } ctrl_t;

  localparam int CTRL_BITS = $bits(ctrl_t);

  // flags are regwrite..userd2 in struct order
  function automatic ctrl_t mk_ctrl(input logic [10:0] flags, input logic [2:0] aluop);
    return ctrl_t'({flags, aluop});
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-group input and decoded-issue output handshakes of the decode stage.
// master drives the group and the downstream accept; slave is the decode stage.
interface decode_stage_if #(
  parameter int LANES  = 2,
  parameter int CTRL_W = 14
);
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*32-1:0]     in_instr;
  logic [LANES-1:0]        in_mask;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*CTRL_W-1:0] out_ctrl;
  logic [LANES-1:0]        out_mask;
  logic [LANES-1:0]        out_illegal;
  logic [LANES*32-1:0]     out_instr;

  modport master (
    output in_valid, in_instr, in_mask, out_ready,
    input  in_ready, out_valid, out_ctrl, out_mask, out_illegal, out_instr
  );

  modport slave (
    input  in_valid, in_instr, in_mask, out_ready,
    output in_ready, out_valid, out_ctrl, out_mask, out_illegal, out_instr
  );
endinterface

// File: rtl/lane_decode.sv
// Combinational single-lane decode: opcode -> control bundle, illegal flag, dest and sources.
// Zero latency, no handshake.
module lane_decode
  import mips_pkg::*;
(
  input  logic [31:11] instr_hi,
  output ctrl_t        ctrl,
  output logic         illegal,
  output logic [4:0]   dest,
  output logic         dest_vld,
  output logic [4:0]   src1,
  output logic         src1_vld,
  output logic [4:0]   src2,
  output logic         src2_vld
);
  logic [5:0] opcode;
  logic [4:0] rs, rt, rd;

  assign opcode = instr_hi[31:26];
  assign rs     = instr_hi[25:21];
  assign rt     = instr_hi[20:16];
  assign rd     = instr_hi[15:11];

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: ctrl = mk_ctrl(11'b1_100_000_00_11, ALU_R);
      OP_ADDI:  ctrl = mk_ctrl(11'b1_010_000_00_10, ALU_ADD);
      OP_ANDI:  ctrl = mk_ctrl(11'b1_010_000_00_10, ALU_AND);
      OP_ORI:   ctrl = mk_ctrl(11'b1_010_000_00_10, ALU_OR);
      OP_SLTI:  ctrl = mk_ctrl(11'b1_010_000_00_10, ALU_SLT);
      OP_LW:    ctrl = mk_ctrl(11'b1_010_001_00_11, ALU_ADD);
      OP_SW:    ctrl = mk_ctrl(11'b0_010_010_00_11, ALU_ADD);
      OP_BEQ:   ctrl = mk_ctrl(11'b0_001_000_00_11, ALU_SUB);
      OP_BNE:   ctrl = mk_ctrl(11'b0_000_100_00_11, ALU_SUB);
      OP_J:     ctrl = mk_ctrl(11'b0_010_000_10_00, ALU_ADD);
      OP_JAL:   ctrl = mk_ctrl(11'b1_010_000_11_00, ALU_ADD);
      default:  illegal = 1'b1;
    endcase
  end

  always_comb begin
    if (ctrl.jumplink)    dest = 5'd31;
    else if (ctrl.regdst) dest = rd;
    else                  dest = rt;
  end

  // writes to $0 never create a hazard
  assign dest_vld = ctrl.regwrite && (dest != 5'd0);
  assign src1     = rs;
  assign src1_vld = ctrl.userd1;
  assign src2     = rt;
  assign src2_vld = ctrl.userd2;

endmodule

// File: rtl/decode_stage.sv
// Multi-lane decode: holds one fetch group, issues the oldest hazard-free prefix each cycle.
// One cycle accept-to-issue; a RAW split stalls the input until the residual lanes drain.
module decode_stage
  import mips_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int CTRL_W = 14
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  decode_stage_if.slave  bus
);
  logic [LANES*32-1:0] h_q;
  logic [LANES-1:0]    p_q;

  ctrl_t            lane_ctrl [LANES];
  logic [4:0]       dst [LANES];
  logic [4:0]       s1  [LANES];
  logic [4:0]       s2  [LANES];
  logic [LANES-1:0] lane_ill, dvld, s1v, s2v;
  logic [LANES-1:0] conflict, issued;
  logic             blocked;
  logic             accept;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_decode u_lane (
      .instr_hi (h_q[g*32+11 +: 21]),
      .ctrl     (lane_ctrl[g]),
      .illegal  (lane_ill[g]),
      .dest     (dst[g]),
      .dest_vld (dvld[g]),
      .src1     (s1[g]),
      .src1_vld (s1v[g]),
      .src2     (s2[g]),
      .src2_vld (s2v[g])
    );
  end

  // Only still-pending older lanes can hazard; issued ones have left the group.
  always_comb begin
    conflict = '0;
    issued   = '0;
    blocked  = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      for (int j = 0; j < LANES; j++) begin
        if (j < k && p_q[j] && dvld[j] &&
            ((s1v[k] && dst[j] == s1[k]) || (s2v[k] && dst[j] == s2[k])))
          conflict[k] = 1'b1;
      end
      if (p_q[k] && conflict[k]) blocked = 1'b1;
      issued[k] = p_q[k] && !blocked;
    end
  end

  always_comb begin
    bus.out_ctrl    = '0;
    bus.out_illegal = '0;
    for (int l = 0; l < LANES; l++) begin
      if (issued[l]) begin
        bus.out_ctrl[l*CTRL_W +: CTRL_W] = CTRL_W'(lane_ctrl[l]);
        bus.out_illegal[l]               = lane_ill[l];
      end
    end
  end

  assign bus.out_valid = |p_q;
  assign bus.out_mask  = issued;
  assign bus.out_instr = h_q;
  assign bus.in_ready  = !flush &&
                         ((p_q == '0) || (bus.out_ready && ((p_q & ~issued) == '0)));
  assign accept        = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= '0;
      p_q <= '0;
    end else if (flush) begin
      p_q <= '0;
    end else if (accept) begin
      h_q <= bus.in_instr;
      p_q <= bus.in_mask;
    end else if (bus.out_valid && bus.out_ready) begin
      p_q <= p_q & ~issued;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage with LANES=2: expected issue beats queued at drive time,
// popped by a negedge monitor on every out_valid && out_ready.
module tb_decode_stage;
  localparam int LANES  = 2;
  localparam int CTRL_W = 14;

  typedef struct {
    logic [1:0]  mask;
    logic [1:0]  ill;
    logic [27:0] ctrl;
    logic [63:0] instr;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;
  beat_t sb[$];

  always #5 clk = ~clk;

  decode_stage_if #(.LANES(LANES), .CTRL_W(CTRL_W)) bus ();

  decode_stage #(.LANES(LANES), .CTRL_W(CTRL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] add_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd);
    return {6'b000000, rs, rt, rd, 5'd0, 6'b100000};
  endfunction

  function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  function automatic logic [13:0] ref_ctrl(input logic [5:0] op);
    case (op)
      6'b000000: return 14'b1_100_000_00_11_000;
      6'b001000: return 14'b1_010_000_00_10_001;
      6'b001100: return 14'b1_010_000_00_10_011;
      6'b001101: return 14'b1_010_000_00_10_100;
      6'b001010: return 14'b1_010_000_00_10_101;
      6'b100011: return 14'b1_010_001_00_11_001;
      6'b101011: return 14'b0_010_010_00_11_001;
      6'b000100: return 14'b0_001_000_00_11_010;
      6'b000101: return 14'b0_000_100_00_11_010;
      6'b000010: return 14'b0_010_000_10_00_001;
      6'b000011: return 14'b1_010_000_11_00_001;
      default:   return 14'b0;
    endcase
  endfunction

  function automatic logic [27:0] exp_ctrl(input logic [1:0] mask, input logic [63:0] instr);
    logic [27:0] r;
    r = '0;
    for (int l = 0; l < 2; l++)
      if (mask[l]) r[l*14 +: 14] = ref_ctrl(instr[l*32+26 +: 6]);
    return r;
  endfunction

  task automatic push(input logic [1:0] mask, input logic [1:0] ill, input logic [63:0] instr);
    beat_t b;
    b.mask  = mask;
    b.ill   = ill;
    b.ctrl  = exp_ctrl(mask, instr);
    b.instr = instr;
    sb.push_back(b);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [63:0] instr, input logic [1:0] mask, output int waited);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_mask  = mask;
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!bus.in_ready) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((sb.size() != 0 || bus.out_valid) && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("drain_in_time", 64'(c < 50), 64'd1);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_issue", 64'(bus.out_mask), 64'd0);
      end else begin
        beat_t b;
        b = sb.pop_front();
        chk("sb_mask",    64'(bus.out_mask),    64'(b.mask));
        chk("sb_illegal", 64'(bus.out_illegal), 64'(b.ill));
        chk("sb_ctrl",    64'(bus.out_ctrl),    64'(b.ctrl));
        chk("sb_instr",   bus.out_instr,        b.instr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got still running want finished");
    $fatal(1);
  end

  initial begin
    logic [63:0] g, ga, gb;
    int w;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_mask   = '0;
    bus.out_ready = 1'b0;

    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid",   64'(bus.out_valid),   64'd0);
    chk("rst_out_mask",    64'(bus.out_mask),    64'd0);
    chk("rst_out_ctrl",    64'(bus.out_ctrl),    64'd0);
    chk("rst_out_illegal", 64'(bus.out_illegal), 64'd0);
    chk("rst_in_ready",    64'(bus.in_ready),    64'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // full-width issue
    bus.out_ready = 1'b1;
    g = {itype(6'b001101, 5'd0, 5'd2, 16'd3), itype(6'b001000, 5'd0, 5'd1, 16'd5)};
    push(2'b11, 2'b00, g);
    send(g, 2'b11, w);
    drain();

    // RAW split: lane1 reads $1 written by lane0
    g = {add_r(5'd1, 5'd2, 5'd3), itype(6'b001000, 5'd0, 5'd1, 16'd5)};
    push(2'b01, 2'b00, g);
    push(2'b10, 2'b00, g);
    send(g, 2'b11, w);
    @(negedge clk);
    chk("split1_mask",  64'(bus.out_mask), 64'b01);
    chk("split1_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    chk("split2_mask",  64'(bus.out_mask), 64'b10);
    chk("split2_ready", 64'(bus.in_ready), 64'd1);
    drain();

    // undefined opcode in lane1 issues alongside lane0
    g = {6'b111111, 5'd1, 5'd1, 16'h0, itype(6'b001000, 5'd0, 5'd1, 16'd5)};
    push(2'b11, 2'b10, g);
    send(g, 2'b11, w);
    drain();

    // downstream stall with a second group waiting
    bus.out_ready = 1'b0;
    ga = {itype(6'b001101, 5'd0, 5'd2, 16'd3), itype(6'b001000, 5'd0, 5'd4, 16'd1)};
    gb = {itype(6'b001100, 5'd0, 5'd6, 16'd7), itype(6'b001010, 5'd0, 5'd7, 16'd1)};
    push(2'b11, 2'b00, ga);
    push(2'b11, 2'b00, gb);
    send(ga, 2'b11, w);
    bus.in_valid = 1'b1;
    bus.in_instr = gb;
    bus.in_mask  = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_mask",  64'(bus.out_mask), 64'b11);
      chk("stall_ctrl",  64'(bus.out_ctrl), 64'(exp_ctrl(2'b11, ga)));
      chk("stall_ready", 64'(bus.in_ready), 64'd0);
      chk("stall_hold",  bus.out_instr,     ga);
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    drain();

    // flush while the split residual is pending
    g = {add_r(5'd1, 5'd2, 5'd3), itype(6'b001000, 5'd0, 5'd1, 16'd9)};
    push(2'b01, 2'b00, g);
    send(g, 2'b11, w);
    @(posedge clk); #1;
    flush = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
    chk("flush_residual", 64'(bus.out_mask), 64'b10);
    @(posedge clk); #1;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    end
    chk("flush_ready_after", 64'(bus.in_ready), 64'd1);
    drain();

    // asynchronous reset mid-stream
    bus.out_ready = 1'b0;
    g = {itype(6'b001101, 5'd0, 5'd2, 16'd3), itype(6'b001000, 5'd0, 5'd1, 16'd5)};
    send(g, 2'b11, w);
    @(negedge clk);
    chk("prerst_out_valid", 64'(bus.out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_out_mask",  64'(bus.out_mask),  64'd0);
    chk("arst_out_ctrl",  64'(bus.out_ctrl),  64'd0);
    chk("arst_in_ready",  64'(bus.in_ready),  64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("postrst_out_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;

    // empty group is accepted and dropped
    send(g, 2'b00, w);
    @(negedge clk);
    chk("empty_out_valid", 64'(bus.out_valid), 64'd0);
    chk("empty_in_ready",  64'(bus.in_ready),  64'd1);
    @(posedge clk); #1;

    // back-to-back groups covering the remaining opcodes
    ga = {itype(6'b101011, 5'd2, 5'd6, 16'd4), itype(6'b100011, 5'd1, 5'd5, 16'd0)};
    push(2'b11, 2'b00, ga);
    send(ga, 2'b11, w);
    g = {itype(6'b000101, 5'd3, 5'd4, 16'd2), itype(6'b000100, 5'd1, 5'd2, 16'd1)};
    push(2'b11, 2'b00, g);
    send(g, 2'b11, w);
    chk("b2b_wait_branch", 64'(w), 64'd0);
    g = {jtype(6'b000011, 26'h40), jtype(6'b000010, 26'h10)};
    push(2'b11, 2'b00, g);
    send(g, 2'b11, w);
    chk("b2b_wait_jump", 64'(w), 64'd0);
    // write to $0 never hazards
    g = {add_r(5'd0, 5'd0, 5'd3), itype(6'b001000, 5'd0, 5'd0, 16'd1)};
    push(2'b11, 2'b00, g);
    send(g, 2'b11, w);
    chk("b2b_wait_r0", 64'(w), 64'd0);
    drain();

    // jal link register feeds the next lane
    g = {add_r(5'd31, 5'd0, 5'd7), jtype(6'b000011, 26'h80)};
    push(2'b01, 2'b00, g);
    push(2'b10, 2'b00, g);
    send(g, 2'b11, w);
    drain();

    // masked-off older lane cannot create a hazard
    g = {add_r(5'd1, 5'd2, 5'd3), itype(6'b001000, 5'd0, 5'd1, 16'd5)};
    push(2'b10, 2'b00, g);
    send(g, 2'b10, w);
    drain();

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter LANES, default 2, SHALL set instructions per fetch group (1..8).
REQ-002 Parameter CTRL_W, default 14, SHALL set control-bundle width per lane.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 flush  in  1  SHALL discard all held, unissued lanes.
REQ-006 in_valid  in  1  SHALL mark a fetch group as offered.
REQ-007 in_ready  out  1  SHALL mark that the group is accepted this cycle.
REQ-008 in_instr  in  LANES*32  SHALL carry the instructions, with lane 0 in the LSBs and oldest first.
REQ-009 in_mask  in  LANES  SHALL carry per-lane instruction valid bits.
REQ-010 out_valid  out  1  SHALL be high when at least one lane is issuable.
REQ-011 out_ready  in  1  SHALL be the downstream accept.
REQ-012 out_ctrl  out  LANES*CTRL_W  SHALL carry per-lane {regwrite,regdst,alusrc,branchbeq,branchneq,memwrite,memtoreg,jump,jumplink,userd1,userd2,aluop[2:0]}.
REQ-013 out_mask  out  LANES  SHALL flag the lanes issued this cycle.
REQ-014 out_illegal  out  LANES  SHALL flag issued lanes that carry an undefined opcode.
REQ-015 out_instr  out  LANES*32  SHALL pass the held instructions through unchanged.

Function
REQ-016 An accepted group (in_valid && in_ready) SHALL be captured into a holding register H, with pending mask P set to in_mask; decode SHALL be combinational from H, giving one cycle of latency from accept to out_valid.
REQ-017 The per-lane opcode table SHALL be as follows (regwrite..aluop, in binary):
- 000000 = 1_100_000_00_11_000
- 001000 addi = 1_010_000_00_10_001
- 001100 andi = 1_010_000_00_10_011
- 001101 ori = 1_010_000_00_10_100
- 001010 slti = 1_010_000_00_10_101
- 100011 lw = 1_010_001_00_11_001
- 101011 sw = 0_010_010_00_11_001
- 000100 beq = 0_001_000_00_11_010
- 000101 bne = 0_000_100_00_11_010
- 000010 j = 0_010_000_10_00_001
- 000011 jal = 1_010_000_11_00_001
REQ-018 Any other opcode SHALL decode to an all-zero bundle with out_illegal set; such a lane SHALL still be issued in order.
REQ-019 Destination register SHALL be 31 when jumplink=1, rd when regdst=1, and rt otherwise; it SHALL be valid only when regwrite=1 and the register is non-zero.
REQ-020 Sources SHALL be rs when userd1=1 and rt when userd2=1.
REQ-021 Intra-group RAW: pending lane k SHALL conflict if any older pending lane j<k has a valid destination equal to a used source of lane k.
REQ-022 The issued set SHALL be the pending lanes older than the first conflicting pending lane. The oldest pending lane SHALL never conflict.
REQ-023 out_valid SHALL equal |P, and out_mask SHALL equal the issued set; out_ctrl and out_illegal SHALL be zero for unissued lanes.
REQ-024 On out_valid && out_ready, P SHALL update to P & ~issued. Otherwise outputs SHALL hold stable (no retraction).
REQ-025 in_ready SHALL equal (P==0) || (out_ready && (P & ~issued)==0), giving back-to-back groups with no bubble when no split occurs.
REQ-026 A group with in_mask all zero SHALL be accepted and dropped, with P staying 0.
REQ-027 Flush SHALL clear P next edge; in_ready SHALL be 0 during flush. Flush SHALL override a simultaneous accept or issue.

Reset
REQ-028 While rst_n=0, the block SHALL drive P=0, H=0, out_valid=0, out_mask=0, out_illegal=0, out_ctrl=0, and in_ready=1 (once flush=0). Reset mid-split SHALL drop the residual lanes.

Structure
REQ-029 The opcode localparams, the aluop codes (000 R/shift/jr, 001 add, 010 sub, 011 and, 100 or, 101 slt), and a packed ctrl_t struct SHALL live in a shared package mips_pkg.
REQ-030 A per-lane combinational sub-module lane_decode (opcode -> ctrl_t, illegal, dest, sources) SHALL be instantiated LANES times.

Verification
REQ-031 With LANES=2, accept {addi $1,$0,5 ; ori $2,$0,3}, mask 11, out_ready=1 -> next cycle out_mask=11, lane0 ctrl 1_010_000_00_10_001, lane1 ctrl 1_010_000_00_10_100.
REQ-032 Accept {addi $1 ; add $3,$1,$2} -> cycle 1 out_mask=01 and in_ready=0; cycle 2 out_mask=10 and in_ready=1.
REQ-033 Lane1 opcode 111111 -> out_illegal=10 and lane1 ctrl all zero, issued together with lane0.
REQ-034 Hold out_ready=0 for 3 cycles with P=11 -> out_ctrl and out_mask stable, in_ready=0, and no new group captured.
REQ-035 Flush during the split residual of REQ-032 -> out_valid=0 next cycle and lane1 never issued.
REQ-036 Assert rst_n=0 mid-stream asynchronously -> out_valid=0 immediately without a clock edge.
